pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_AW, 5, register address width; register 0 is hard-wired zero.
REQ-002 Parameter LOAD_BUBBLES, 1, bubbles inserted on a load-use hazard; legal range 1..3.
REQ-003 Parameter PERF_W, 32, perf counter width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (low = reset).
REQ-006 rs1_en_d, rs2_en_d  in  1 each  source read enables of the instruction in D.
REQ-007 rs1_addr_d, rs2_addr_d  in  REG_AW each  source addresses in D.
REQ-008 rd_we_e, rd_addr_e, load_e  in  1/REG_AW/1  destination write enable, destination address, and load flag of the instruction in E.
REQ-009 rd_we_m, rd_addr_m  in  1/REG_AW  destination of the instruction in M.
REQ-010 rd_we_w, rd_addr_w  in  1/REG_AW  destination of the instruction in W.
REQ-011 jump_e  in  1  taken branch/jump resolved in E.
REQ-012 mem_req_m, mem_ready_m  in  1 each  M-stage memory request and completion handshake.
REQ-013 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC / D / E / M pipeline registers.
REQ-014 flush_d, flush_e  out  1 each  load a bubble into the D / E registers.
REQ-015 fwd1_sel, fwd2_sel  out  2 each  E-operand source: 00 regfile, 01 M result, 10 W result.
REQ-016 perf_stall_cnt, perf_flush_cnt  out  PERF_W each  performance counters (see Configuration).

Function
REQ-017 State machine: RUN, LDSTALL, MEMWAIT.
REQ-018 MEMWAIT entered when mem_req_m=1 and mem_ready_m=0; exited in the cycle mem_ready_m=1, back to the state held before entry.
REQ-019 MEMWAIT outputs: all stalls = 1, all flushes = 0; combinational in the same cycle the wait starts.
REQ-020 jump_e asserted during MEMWAIT is latched; applied in the cycle mem_ready_m=1.
REQ-021 Jump application: flush_d=1 and flush_e=1 for exactly one cycle; stall_f=0, so the PC takes the jump target.
REQ-022 Load-use hazard: load_e=1, rd_we_e=1, rd_addr_e!=0, and (rs1_en_d and rs1_addr_d==rd_addr_e, or rs2_en_d and rs2_addr_d==rd_addr_e).
REQ-023 On a hazard in RUN: stall_f=stall_d=1 and flush_e=1 for LOAD_BUBBLES consecutive cycles, counted by a down-counter; the FSM sits in LDSTALL after the first cycle and returns to RUN when the counter reaches 0.
REQ-024 Priority: MEMWAIT > jump > load-use.
REQ-025 A jump applied while in LDSTALL clears the counter and returns the FSM to RUN.
REQ-026 Forwarding for each operand, evaluated combinationally against E-stage sources registered from D:
- M match has priority over W match.
- A match requires the matching stage's write enable.
- Address 0 never forwards.
- Operand disabled gives 00.
REQ-027 rs1/rs2 addresses and enables are captured into E-side registers when stall_e=0.
- flush_e clears them (enables = 0).
- stall_e holds them.

Reset
REQ-028 While rst=0:
- FSM = RUN, counter = 0, latched jump = 0, E-side source registers cleared.
- All stall/flush outputs = 0, fwd selects = 00, perf counters = 0.
REQ-029 Reset asserted mid-MEMWAIT or mid-LDSTALL aborts the sequence immediately; no pending jump survives.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN, when defined:
- perf_stall_cnt increments in every cycle with stall_d=1.
- perf_flush_cnt increments in every cycle with flush_d=1 or flush_e=1.
- Both counters saturate at all-ones.
REQ-031 Without PIPE_CTRL_PERF_EN: both counter ports are driven constant 0, no counter flops exist, and all other behaviour is identical.

Verification
REQ-032 Load x5 in E, D reads rs1=x5, LOAD_BUBBLES=1 -> one cycle of stall_f=stall_d=flush_e=1; next cycle fwd1_sel=10.
REQ-033 Same hazard with LOAD_BUBBLES=3 -> exactly 3 stall cycles; perf_stall_cnt=3 with PIPE_CTRL_PERF_EN.
REQ-034 mem_req_m=1, mem_ready_m=0 for 4 cycles, jump_e pulsed in cycle 2 -> all stalls=1 for 4 cycles; flush_d=flush_e=1 in the ready cycle only.
REQ-035 rd_addr_m=rd_addr_w=x7, both write enables=1, E source x7 -> fwd_sel=01; same stimulus with x0 -> 00.
REQ-036 rst driven low during LDSTALL cycle 2 of 3 -> all outputs 0 asynchronously; after release, no stall resumes.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/forwarding controller for a 5-stage pipeline.
// Optional saturating performance counters when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs1_en_d,
  input  logic              rs2_en_d,
  input  logic [REG_AW-1:0] rs1_addr_d,
  input  logic [REG_AW-1:0] rs2_addr_d,
  input  logic              rd_we_e,
  input  logic [REG_AW-1:0] rd_addr_e,
  input  logic              load_e,
  input  logic              rd_we_m,
  input  logic [REG_AW-1:0] rd_addr_m,
  input  logic              rd_we_w,
  input  logic [REG_AW-1:0] rd_addr_w,
  input  logic              jump_e,
  input  logic              mem_req_m,
  input  logic              mem_ready_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd1_sel,
  output logic [1:0]        fwd2_sel,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);
  // RUN: normal issue | LDSTALL: load-use bubbles pending | MEMWAIT: M-stage memory wait
  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, MEMWAIT = 2'd2} state_t;

  localparam logic [1:0] LB_RELOAD = 2'(LOAD_BUBBLES - 1);

  state_t            r_state, r_ret_state, w_state_nxt, w_ret_nxt, w_eff;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic              r_jump_pend, w_jump_nxt;
  logic              w_mem_wait, w_hazard;
  logic              w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_d, w_flush_e;
  logic              r_rs1_en_e, r_rs2_en_e;
  logic [REG_AW-1:0] r_rs1_addr_e, r_rs2_addr_e;

  assign w_mem_wait = mem_req_m & ~mem_ready_m;
  assign w_hazard   = load_e & rd_we_e & (rd_addr_e != '0) &
                      ((rs1_en_d & (rs1_addr_d == rd_addr_e)) |
                       (rs2_en_d & (rs2_addr_d == rd_addr_e)));
  assign w_eff      = (r_state == MEMWAIT) ? r_ret_state : r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_cnt       <= '0;
      r_jump_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_cnt       <= w_cnt_nxt;
      r_jump_pend <= w_jump_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_state;
    w_cnt_nxt   = r_cnt;
    w_jump_nxt  = r_jump_pend;
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_stall_m   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    if (w_mem_wait) begin
      w_stall_f   = 1'b1;
      w_stall_d   = 1'b1;
      w_stall_e   = 1'b1;
      w_stall_m   = 1'b1;
      w_state_nxt = MEMWAIT;
      w_ret_nxt   = w_eff;
      w_jump_nxt  = r_jump_pend | jump_e;
    end else begin
      w_jump_nxt  = 1'b0;
      w_state_nxt = w_eff;
      if (jump_e | r_jump_pend) begin
        w_flush_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = RUN;
      end else if (w_eff == LDSTALL) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
        w_cnt_nxt = r_cnt - 2'd1;
        if (w_cnt_nxt == '0) w_state_nxt = RUN;
      end else if (w_hazard) begin
        w_stall_f   = 1'b1;
        w_stall_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_cnt_nxt   = LB_RELOAD;
        w_state_nxt = (LB_RELOAD != '0) ? LDSTALL : RUN;
      end
    end
  end

  // Pipeline controls are forced idle for the whole time reset is low.
  assign stall_f = rst & w_stall_f;
  assign stall_d = rst & w_stall_d;
  assign stall_e = rst & w_stall_e;
  assign stall_m = rst & w_stall_m;
  assign flush_d = rst & w_flush_d;
  assign flush_e = rst & w_flush_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs1_en_e   <= 1'b0;
      r_rs2_en_e   <= 1'b0;
      r_rs1_addr_e <= '0;
      r_rs2_addr_e <= '0;
    end else if (!w_stall_e) begin
      r_rs1_en_e   <= w_flush_e ? 1'b0 : rs1_en_d;
      r_rs2_en_e   <= w_flush_e ? 1'b0 : rs2_en_d;
      r_rs1_addr_e <= w_flush_e ? '0 : rs1_addr_d;
      r_rs2_addr_e <= w_flush_e ? '0 : rs2_addr_d;
    end
  end

  function automatic logic [1:0] fwd_sel_f(input logic en, input logic [REG_AW-1:0] addr,
                                           input logic we_m, input logic [REG_AW-1:0] a_m,
                                           input logic we_w, input logic [REG_AW-1:0] a_w);
    if (!en || addr == '0) return 2'b00;
    if (we_m && a_m == addr) return 2'b01;
    if (we_w && a_w == addr) return 2'b10;
    return 2'b00;
  endfunction

  assign fwd1_sel = fwd_sel_f(r_rs1_en_e, r_rs1_addr_e, rd_we_m, rd_addr_m, rd_we_w, rd_addr_w);
  assign fwd2_sel = fwd_sel_f(r_rs2_en_e, r_rs2_addr_e, rd_we_m, rd_addr_m, rd_we_w, rd_addr_w);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_stall, r_perf_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (stall_d && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + PERF_W'(1);
      if ((flush_d || flush_e) && !(&r_perf_flush)) r_perf_flush <= r_perf_flush + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, corner-case sequences and a
// randomized run against a cycle-level behavioural model (two LOAD_BUBBLES builds).
module tb_pipe_ctrl;
  localparam int AW = 5;
  localparam int PW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mreq, mrdy, jmp, lde, wee, wem, wew, en1, en2;
  logic [AW-1:0] rde, rdm, rdw, a1, a2;

  logic [1:0] sf, sd, se, sm, fd, fe;
  logic [1:0] f1s [2];
  logic [1:0] f2s [2];
  logic [PW-1:0] pst [2];
  logic [PW-1:0] pfl [2];

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(1), .PERF_W(PW)) u_dut1 (
    .clk(clk), .rst(rst), .rs1_en_d(en1), .rs2_en_d(en2), .rs1_addr_d(a1), .rs2_addr_d(a2),
    .rd_we_e(wee), .rd_addr_e(rde), .load_e(lde), .rd_we_m(wem), .rd_addr_m(rdm),
    .rd_we_w(wew), .rd_addr_w(rdw), .jump_e(jmp), .mem_req_m(mreq), .mem_ready_m(mrdy),
    .stall_f(sf[0]), .stall_d(sd[0]), .stall_e(se[0]), .stall_m(sm[0]),
    .flush_d(fd[0]), .flush_e(fe[0]), .fwd1_sel(f1s[0]), .fwd2_sel(f2s[0]),
    .perf_stall_cnt(pst[0]), .perf_flush_cnt(pfl[0]));

  pipe_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(3), .PERF_W(PW)) u_dut3 (
    .clk(clk), .rst(rst), .rs1_en_d(en1), .rs2_en_d(en2), .rs1_addr_d(a1), .rs2_addr_d(a2),
    .rd_we_e(wee), .rd_addr_e(rde), .load_e(lde), .rd_we_m(wem), .rd_addr_m(rdm),
    .rd_we_w(wew), .rd_addr_w(rdw), .jump_e(jmp), .mem_req_m(mreq), .mem_ready_m(mrdy),
    .stall_f(sf[1]), .stall_d(sd[1]), .stall_e(se[1]), .stall_m(sm[1]),
    .flush_d(fd[1]), .flush_e(fe[1]), .fwd1_sel(f1s[1]), .fwd2_sel(f2s[1]),
    .perf_stall_cnt(pst[1]), .perf_flush_cnt(pfl[1]));

  // Behavioural model state, one slot per instance (0: 1 bubble, 1: 3 bubbles).
  int            m_bub [2];
  bit            m_jp  [2];
  bit            m_e1  [2];
  bit            m_e2  [2];
  logic [AW-1:0] m_a1  [2];
  logic [AW-1:0] m_a2  [2];
  longint        m_ps  [2];
  longint        m_pf  [2];
  localparam longint PMAX = 64'h0000_0000_FFFF_FFFF;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bub[k] = 0; m_jp[k] = 0; m_e1[k] = 0; m_e2[k] = 0;
      m_a1[k] = '0; m_a2[k] = '0; m_ps[k] = 0; m_pf[k] = 0;
    end
  endtask

  function automatic logic [1:0] fsel(input bit en, input logic [AW-1:0] a);
    if (!en || a == 0) return 2'b00;
    if (wem && rdm == a) return 2'b01;
    if (wew && rdw == a) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval(input int k, output logic [9:0] ev, output longint eps, output longint epf);
    bit s_f, s_d, s_e, s_m, f_d, f_e, haz;
    logic [1:0] x1, x2;
    int lb;
    lb = (k == 0) ? 1 : 3;
    s_f = 0; s_d = 0; s_e = 0; s_m = 0; f_d = 0; f_e = 0;
    if (!rst) begin
      m_bub[k] = 0; m_jp[k] = 0; m_e1[k] = 0; m_e2[k] = 0;
      m_a1[k] = '0; m_a2[k] = '0; m_ps[k] = 0; m_pf[k] = 0;
      ev = '0; eps = 0; epf = 0;
      return;
    end
    x1 = fsel(m_e1[k], m_a1[k]);
    x2 = fsel(m_e2[k], m_a2[k]);
    haz = lde && wee && rde != 0 && ((en1 && a1 == rde) || (en2 && a2 == rde));
    if (mreq && !mrdy) begin
      {s_f, s_d, s_e, s_m} = 4'hF;
      m_jp[k] = m_jp[k] | jmp;
    end else if (jmp || m_jp[k]) begin
      m_jp[k] = 0; f_d = 1; f_e = 1; m_bub[k] = 0;
    end else if (m_bub[k] > 0) begin
      s_f = 1; s_d = 1; f_e = 1; m_bub[k]--;
    end else if (haz) begin
      s_f = 1; s_d = 1; f_e = 1; m_bub[k] = lb - 1;
    end
    ev = {s_f, s_d, s_e, s_m, f_d, f_e, x1, x2};
`ifdef PIPE_CTRL_PERF_EN
    eps = m_ps[k]; epf = m_pf[k];
`else
    eps = 0; epf = 0;
`endif
    if (!s_e) begin
      m_e1[k] = f_e ? 1'b0 : en1;  m_a1[k] = f_e ? '0 : a1;
      m_e2[k] = f_e ? 1'b0 : en2;  m_a2[k] = f_e ? '0 : a2;
    end
    if (s_d && m_ps[k] < PMAX) m_ps[k]++;
    if ((f_d || f_e) && m_pf[k] < PMAX) m_pf[k]++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] act_v(input int k);
    return {sf[k], sd[k], se[k], sm[k], fd[k], fe[k], f1s[k], f2s[k]};
  endfunction

  // Samples on the falling edge; checks both instances against the model.
  task automatic tick(input string tag, input bit use_tbl, input logic [9:0] tv);
    logic [9:0] ev;
    longint eps, epf;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_eval(k, ev, eps, epf);
      chk($sformatf("%s_out%0d", tag, k), act_v(k), ev);
      chk($sformatf("%s_pstall%0d", tag, k), pst[k], eps);
      chk($sformatf("%s_pflush%0d", tag, k), pfl[k], epf);
    end
    if (use_tbl) chk($sformatf("%s_tbl", tag), act_v(0), tv);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mreq = 0; mrdy = 0; jmp = 0; lde = 0; wee = 0; rde = '0; wem = 0; rdm = '0;
    wew = 0; rdw = '0; en1 = 0; a1 = '0; en2 = 0; a2 = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle();
    tick("reset", 0, '0);
    chk("reset_state", {act_v(0), act_v(1)}, '0);
    adv();
    rst = 1;
  endtask

  // Inputs {req,rdy,jmp,ld}, E/M/W destinations, D sources; expect {sf,sd,se,sm,fd,fe,fwd1,fwd2} (LOAD_BUBBLES=1).
  typedef struct {
    logic [3:0] ctl;
    logic we_e; logic [AW-1:0] rd_e;
    logic we_m; logic [AW-1:0] rd_m;
    logic we_w; logic [AW-1:0] rd_w;
    logic e1; logic [AW-1:0] s1;
    logic e2; logic [AW-1:0] s2;
    logic [9:0] exp;
  } vec_t;

  vec_t vt [24];

  initial begin
    int cnt1, cnt3;
    longint exp_p;
    vt[0]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000_00_00_00};
    vt[1]  = '{4'b0001, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 10'b1100_01_00_00};
    vt[2]  = '{4'b0000, 0, 0, 1, 5, 0, 0, 1, 5, 0, 0, 10'b0000_00_00_00};
    vt[3]  = '{4'b0000, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 10'b0000_00_10_00};
    vt[4]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 10'b0000_00_00_00};
    vt[5]  = '{4'b0000, 0, 0, 1, 7, 1, 7, 1, 0, 1, 0, 10'b0000_00_01_01};
    vt[6]  = '{4'b0000, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 10'b0000_00_00_00};
    vt[7]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 1, 9, 1, 3, 10'b0000_00_00_00};
    vt[8]  = '{4'b0000, 0, 0, 1, 3, 1, 9, 0, 0, 0, 0, 10'b0000_00_10_01};
    vt[9]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 10'b0000_00_00_00};
    vt[10] = '{4'b0000, 0, 0, 0, 4, 0, 4, 1, 4, 0, 0, 10'b0000_00_00_00};
    vt[11] = '{4'b0000, 0, 0, 0, 4, 1, 4, 0, 0, 0, 0, 10'b0000_00_10_00};
    vt[12] = '{4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1111_00_00_00};
    vt[13] = '{4'b1010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1111_00_00_00};
    vt[14] = '{4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1111_00_00_00};
    vt[15] = '{4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1111_00_00_00};
    vt[16] = '{4'b1100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000_11_00_00};
    vt[17] = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000_00_00_00};
    vt[18] = '{4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000_11_00_00};
    vt[19] = '{4'b0001, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 10'b0000_00_00_00};
    vt[20] = '{4'b0001, 0, 6, 0, 0, 0, 0, 0, 0, 1, 6, 10'b0000_00_00_00};
    vt[21] = '{4'b0001, 1, 6, 0, 0, 0, 0, 0, 0, 1, 6, 10'b1100_01_00_00};
    vt[22] = '{4'b0011, 1, 6, 0, 0, 0, 0, 0, 0, 1, 6, 10'b0000_11_00_00};
    vt[23] = '{4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000_00_00_00};

    model_reset();
    do_reset();

    for (int i = 0; i < 24; i++) begin
      {mreq, mrdy, jmp, lde} = vt[i].ctl;
      wee = vt[i].we_e; rde = vt[i].rd_e; wem = vt[i].we_m; rdm = vt[i].rd_m;
      wew = vt[i].we_w; rdw = vt[i].rd_w;
      en1 = vt[i].e1; a1 = vt[i].s1; en2 = vt[i].e2; a2 = vt[i].s2;
      tick($sformatf("vec%0d", i), 1, vt[i].exp);
      adv();
    end

    // Load-use bubble count for both builds, plus perf counters.
    do_reset();
    lde = 1; wee = 1; rde = 5; en1 = 1; a1 = 5;
    cnt1 = 0; cnt3 = 0;
    for (int i = 0; i < 6; i++) begin
      tick("ldseq", 0, '0);
      cnt1 += int'(sd[0]);
      cnt3 += int'(sd[1]);
      adv();
      lde = 0; wee = 0; wem = (i == 0); rdm = 5;
    end
    chk("ld_bubbles_1", cnt1, 1);
    chk("ld_bubbles_3", cnt3, 3);
    tick("ldperf", 0, '0);
`ifdef PIPE_CTRL_PERF_EN
    exp_p = 3;
`else
    exp_p = 0;
`endif
    chk("perf_stall_3", pst[1], exp_p);
    adv();

    // Reset asserted in the second of three load-use bubbles.
    do_reset();
    lde = 1; wee = 1; rde = 5; en1 = 1; a1 = 5;
    tick("rld1", 0, '0);
    adv();
    lde = 0; wee = 0;
    tick("rld2", 0, '0);
    chk("ldstall_cycle2", sd[1], 1);
    #1 rst = 0; mreq = 1; mrdy = 0;
    #1 chk("rst_async_outs", {act_v(0), act_v(1)}, '0);
    chk("rst_async_perf", pst[1], 0);
    model_reset();
    adv();
    rst = 1; mreq = 0;
    cnt3 = 0;
    for (int i = 0; i < 3; i++) begin
      tick("rld_after", 0, '0);
      cnt3 += int'(sd[1]);
      adv();
    end
    chk("no_stall_resume", cnt3, 0);

    // Reset during a memory wait holding a latched jump.
    do_reset();
    mreq = 1; mrdy = 0; jmp = 1;
    tick("rmw1", 0, '0);
    adv();
    jmp = 0;
    tick("rmw2", 0, '0);
    chk("memwait_stalls", {sf[0], sd[0], se[0], sm[0]}, 4'hF);
    #1 rst = 0;
    #1 chk("rst_memwait_outs", {act_v(0), act_v(1)}, '0);
    model_reset();
    adv();
    rst = 1; mrdy = 1;
    tick("rmw_ready", 0, '0);
    chk("no_pending_jump", {fd[0], fe[0], fd[1], fe[1]}, 4'h0);
    adv();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 63) != 0);
      mreq = ($urandom_range(0, 9) < 3);
      mrdy = ($urandom_range(0, 1) == 1);
      jmp  = ($urandom_range(0, 9) == 0);
      lde  = ($urandom_range(0, 9) < 4);
      wee  = ($urandom_range(0, 9) < 7);
      wem  = ($urandom_range(0, 9) < 7);
      wew  = ($urandom_range(0, 9) < 7);
      en1  = ($urandom_range(0, 9) < 7);
      en2  = ($urandom_range(0, 9) < 7);
      rde  = AW'($urandom_range(0, 7));
      rdm  = AW'($urandom_range(0, 7));
      rdw  = AW'($urandom_range(0, 7));
      a1   = AW'($urandom_range(0, 7));
      a2   = AW'($urandom_range(0, 7));
      tick("rand", 0, '0);
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
